gpio_pin_filter: RTL and testbench

Input-conditioning stage placed directly upstream of the GPIO lite block. Its pin_filt output drives the GPIO block's gpio_pin_in.
- Synchronises up to 16 asynchronous pad inputs into the pclk domain.
- Optionally debounces each pin against a shared prescaled tick.
- Emits single-cycle rise/fall pulses on the conditioned value, for status or interrupt use.

---
 rtl/gpio_pin_filter_if.sv | 21 ++
 rtl/gpio_pin_filter.sv | 111 +++++++++++
 tb/tb_gpio_pin_filter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pin_filter_if.sv
// Pin-level bundle between the pad conditioning stage and its consumer.
interface gpio_pin_filter_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pin_raw;
  logic [WIDTH-1:0] filt_en;
  logic [WIDTH-1:0] pin_filt;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             tick;

  modport master (
    output pin_raw, filt_en,
    input  pin_filt, rise, fall, tick
  );

  modport slave (
    input  pin_raw, filt_en,
    output pin_filt, rise, fall, tick
  );
endinterface

// File: rtl/gpio_pin_filter.sv
// GPIO input conditioning: 2-flop synchroniser, optional per-pin debounce
// against a shared prescaled tick, and registered rise/fall pulses.
module gpio_pin_filter_lane #(
  parameter int DEB_TICKS = 4
) (
  input  logic pclk,
  input  logic p_reset,
  input  logic raw_i,
  input  logic en_i,
  input  logic tick_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int DW = $clog2(DEB_TICKS + 1);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic          rise_q, fall_q;
  logic [DW-1:0] dcnt_q, dcnt_d;

  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    if (!en_i) begin
      filt_d = s2_q;
      dcnt_d = '0;
    end else if (s2_q == filt_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      // Last tick of the window commits the new level and rearms the count.
      if (dcnt_q == DW'(DEB_TICKS - 1)) begin
        filt_d = s2_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      dcnt_q <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
      dcnt_q <= dcnt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module gpio_pin_filter #(
  parameter int WIDTH     = 16,
  parameter int PRESCALE  = 16,
  parameter int DEB_TICKS = 4
) (
  input logic              pclk,
  input logic              p_reset,
  gpio_pin_filter_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             tick_q;
  logic             wrap;
  logic [WIDTH-1:0] filt, rise, fall;

  // Free-running prescaler; tick is registered so it lands one cycle after wrap.
  assign wrap   = (pcnt_q == PW'(PRESCALE - 1));
  assign pcnt_d = wrap ? '0 : pcnt_q + PW'(1);

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      pcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick_q <= wrap;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_pin_filter_lane #(.DEB_TICKS(DEB_TICKS)) u_lane (
      .pclk    (pclk),
      .p_reset (p_reset),
      .raw_i   (bus.pin_raw[i]),
      .en_i    (bus.filt_en[i]),
      .tick_i  (tick_q),
      .filt_o  (filt[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  assign bus.pin_filt = filt;
  assign bus.rise     = rise;
  assign bus.fall     = fall;
  assign bus.tick     = tick_q;
endmodule

// File: tb/tb_gpio_pin_filter.sv
// Randomised and directed bench for gpio_pin_filter against a cycle-count model.
module tb_gpio_pin_filter;
  localparam int W = 16;
  localparam int P = 16;
  localparam int D = 4;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  always #5 pclk = ~pclk;

  gpio_pin_filter_if #(.WIDTH(W)) bus ();

  gpio_pin_filter #(.WIDTH(W), .PRESCALE(P), .DEB_TICKS(D)) dut (
    .pclk    (pclk),
    .p_reset (rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: pipeline of sampled raw values, edges since reset, and per-pin
  // count of ticks observed while the synchronised pin disagrees.
  logic [W-1:0] hist[2];
  logic [W-1:0] m_filt, m_rise, m_fall;
  logic         m_tick;
  int           m_k;
  int           m_seen[W];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [W-1:0] raw, input logic [W-1:0] en);
    logic [W-1:0] old;
    logic [W-1:0] sync;
    old  = m_filt;
    sync = hist[1];
    if (r) begin
      hist[0] = '0; hist[1] = '0;
      m_filt = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0; m_k = 0;
      for (int i = 0; i < W; i++) m_seen[i] = 0;
      return;
    end
    for (int i = 0; i < W; i++) begin
      if (!en[i] || sync[i] == m_filt[i]) begin
        if (!en[i]) m_filt[i] = sync[i];
        m_seen[i] = 0;
      end else if (m_tick) begin
        m_seen[i] = m_seen[i] + 1;
        if (m_seen[i] == D) begin
          m_filt[i] = sync[i];
          m_seen[i] = 0;
        end
      end
    end
    hist[1] = hist[0];
    hist[0] = raw;
    m_k++;
    m_tick = (m_k % P) == 0;
    m_rise = m_filt & ~old;
    m_fall = ~m_filt & old;
  endtask

  task automatic cyc();
    logic r;
    logic [W-1:0] raw, en;
    r = rst; raw = bus.pin_raw; en = bus.filt_en;
    @(posedge pclk);
    model_step(r, raw, en);
    #1;
    chk("pin_filt", 32'(bus.pin_filt), 32'(m_filt));
    chk("rise", 32'(bus.rise), 32'(m_rise));
    chk("fall", 32'(bus.fall), 32'(m_fall));
    chk("tick", 32'(bus.tick), 32'(m_tick));
    chk("rise_fall_excl", 32'(|(bus.rise & bus.fall)), 32'd0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int lat, nfall, nrise;
    bus.pin_raw = 16'hFFFF;
    bus.filt_en = 16'h0000;
    rst = 1'b1;
    model_step(1'b1, '0, '0);

    // Reset then bypass latency.
    run(3);
    rst = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (bus.pin_filt == 16'hFFFF) begin lat = n; break; end
    end
    chk("bypass_latency", 32'(lat), 32'd3);
    chk("bypass_rise", 32'(bus.rise), 32'hFFFF);
    cyc();
    chk("bypass_rise_one_cycle", 32'(bus.rise), 32'd0);

    // Debounced rise on pin 0.
    rst = 1'b1; bus.pin_raw = '0; bus.filt_en = 16'h0001;
    run(3);
    rst = 1'b0;
    run(7);
    bus.pin_raw = 16'h0001;
    lat = 0; nrise = 0;
    for (int n = 1; n <= 200; n++) begin
      cyc();
      if (bus.rise[0]) nrise++;
      if (bus.pin_filt[0]) begin lat = n; break; end
    end
    chk("deb_latency_in_window", 32'(lat >= 51 && lat <= 66), 32'd1);
    chk("deb_rise_pulse", 32'(nrise), 32'd1);
    chk("deb_other_bits", 32'(bus.pin_filt[W-1:1]), 32'd0);

    // Bring pin 0 back low, then a 20-cycle glitch.
    bus.pin_raw = '0;
    run(80);
    bus.pin_raw = 16'h0001;
    run(20);
    bus.pin_raw = '0;
    nrise = 0;
    for (int n = 0; n < 100; n++) begin
      cyc();
      if (bus.rise[0] || bus.fall[0]) nrise++;
    end
    chk("glitch_filt", 32'(bus.pin_filt[0]), 32'd0);
    chk("glitch_edges", 32'(nrise), 32'd0);

    // Pins 3 and 7 fall together.
    bus.filt_en = 16'h0089;
    bus.pin_raw = 16'h0088;
    run(80);
    chk("pair_high", 32'(bus.pin_filt), 32'h0088);
    bus.pin_raw = '0;
    nfall = 0;
    for (int n = 0; n < 90; n++) begin
      cyc();
      if (bus.fall != '0) begin
        nfall++;
        chk("pair_fall_mask", 32'(bus.fall), 32'h0088);
      end
    end
    chk("pair_fall_cycles", 32'(nfall), 32'd1);

    // Mode switch mid-count, then re-enabled debounce on the fall.
    bus.pin_raw = 16'h0001;
    run(38);
    bus.filt_en = 16'h0088;
    cyc();
    chk("bypass_switch_filt", 32'(bus.pin_filt[0]), 32'd1);
    chk("bypass_switch_rise", 32'(bus.rise[0]), 32'd1);
    bus.filt_en = 16'h0089;
    bus.pin_raw = '0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      cyc();
      if (!bus.pin_filt[0]) begin lat = n; break; end
    end
    chk("reenable_fall_window", 32'(lat >= 51 && lat <= 66), 32'd1);

    // Reset mid-count with pin_filt high.
    bus.pin_raw = 16'h0001;
    run(80);
    bus.pin_raw = '0;
    run(52);
    rst = 1'b1;
    cyc();
    chk("midrst_filt", 32'(bus.pin_filt), 32'd0);
    chk("midrst_fall", 32'(bus.fall), 32'd0);
    rst = 1'b0;
    bus.pin_raw = 16'h0001;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      cyc();
      if (bus.pin_filt[0]) begin lat = n; break; end
    end
    chk("midrst_rise_window", 32'(lat >= 51 && lat <= 66), 32'd1);

    // Random traffic: sparse pin toggles, occasional mode flips and resets.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] tog;
      tog = '0;
      for (int i = 0; i < W; i++) if ($urandom_range(0, 39) == 0) tog[i] = 1'b1;
      bus.pin_raw = bus.pin_raw ^ tog;
      if ($urandom_range(0, 149) == 0) bus.filt_en = W'($urandom);
      rst = ($urandom_range(0, 799) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
